// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEF_GAP_CYCLES     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 200_000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GAP
    } arb_state_e;

    function automatic int unsigned grant_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above the last grant, with wrap-around.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic               valid_c
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_c   = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!valid_c && req[idx]) begin
                gnt_c[idx] = 1'b1;
                valid_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned IDX_W          = grant_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_start,
    output logic [BYTE_W-1:0]         uart_txin,
    input  logic                      uart_txdone,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      timeout_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 3 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter value");
    end

    arb_state_e          state;
    logic [GAP_W-1:0]    gap_cnt;
    logic [NUM_REQ-1:0]  pick_gnt_c;
    logic                pick_valid_c;
    logic [IDX_W-1:0]    pick_idx_c;
    logic [BYTE_W-1:0]   pick_byte_c;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .last    (grant_id),
        .gnt_c   (pick_gnt_c),
        .valid_c (pick_valid_c)
    );

    // One-hot grant to index and byte select.
    always_comb begin
        pick_idx_c  = '0;
        pick_byte_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt_c[i]) begin
                pick_idx_c  = IDX_W'(i);
                pick_byte_c = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= '0;
            uart_start  <= 1'b0;
            uart_txin   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            grant_id    <= IDX_W'(NUM_REQ - 1);
            gap_cnt     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            req_ready   <= '0;
            uart_start  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        req_ready  <= pick_gnt_c;
                        uart_start <= 1'b1;
                        uart_txin  <= pick_byte_c;
                        grant_id   <= pick_idx_c;
                        busy       <= 1'b1;
                        state      <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (uart_txdone) begin
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                // IDLE is reached as the count hits zero, so the next start lands GAP_CYCLES+1 after txdone.
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        uart_start;
    logic [7:0]  uart_txin;
    logic        uart_txdone;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int         start_q[$];
    logic [7:0] byte_q[$];
    logic [3:0] rdy_q[$];
    int         done_q[$];
    int         to_q[$];

    bit model_en = 1'b0;
    bit done_req = 1'b0;
    int dly      = 100;
    int cd       = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .uart_start  (uart_start),
        .uart_txin   (uart_txin),
        .uart_txdone (uart_txdone),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: txdone arrives dly cycles after the start cycle, or on request.
    always @(posedge clk) begin
        #1;
        uart_txdone = 1'b0;
        if (done_req) begin
            uart_txdone = 1'b1;
            done_req    = 1'b0;
        end else if (model_en) begin
            if (uart_start) begin
                cd = dly;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) uart_txdone = 1'b1;
            end
        end
    end

    // Event log sampled mid-high-phase.
    always @(posedge clk) begin
        #3;
        if (uart_start) begin
            start_q.push_back(cyc);
            byte_q.push_back(uart_txin);
            rdy_q.push_back(req_ready);
        end
        if (uart_txdone) done_q.push_back(cyc);
        if (timeout_err) to_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        start_q.delete();
        byte_q.delete();
        rdy_q.delete();
        done_q.delete();
        to_q.delete();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_en  = 1'b0;
        cd        = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && start_q.size() < n; i++) @(negedge clk);
        check(tag, 32'(start_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag, output int fall);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        check(tag, 32'(busy), 32'd0);
        fall = cyc;
    endtask

    int fall;
    int s0;

    initial begin
        uart_txdone = 1'b0;
        req_data    = '0;

        // Reset values
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("rst busy",      32'(busy),        32'd0);
        check("rst grant_id",  32'(grant_id),    32'd3);
        check("rst start",     32'(uart_start),  32'd0);
        check("rst ready",     32'(req_ready),   32'd0);
        check("rst txin",      32'(uart_txin),   32'd0);
        check("rst timeout",   32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        clear_logs();

        // Single requester, one-cycle latency, busy until gap expires
        model_en  = 1'b1;
        dly       = 20;
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        @(negedge clk);
        check("t1 ready",    32'(req_ready),  32'h1);
        check("t1 start",    32'(uart_start), 32'd1);
        check("t1 txin",     32'(uart_txin),  32'hA5);
        check("t1 grant_id", 32'(grant_id),   32'd0);
        check("t1 busy",     32'(busy),       32'd1);
        req_valid = '0;
        @(negedge clk);
        check("t1 start pulse", 32'(uart_start), 32'd0);
        check("t1 ready pulse", 32'(req_ready),  32'd0);
        wait_idle(100, "t1 idle bound", fall);
        check("t1 done count", 32'(done_q.size()), 32'd1);
        if (done_q.size() == 1) check("t1 busy fall", 32'(fall - done_q[0]), 32'd4);
        check("t1 single start", 32'(start_q.size()), 32'd1);

        // Four requesters continuously valid: rotation and start spacing
        apply_reset();
        model_en  = 1'b1;
        dly       = 100;
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        wait_starts(5, 700, "t2 start bound");
        req_valid = '0;
        for (int i = 0; i < 5 && i < byte_q.size(); i++)
            check($sformatf("t2 byte%0d", i), 32'(byte_q[i]), 32'h10 + 32'(i % 4));
        for (int i = 0; i < 4 && i + 1 < start_q.size(); i++)
            check($sformatf("t2 spacing%0d", i), 32'(start_q[i+1] - start_q[i]), 32'd105);
        wait_idle(300, "t2 idle bound", fall);

        // Back-to-back single requester: gap enforcement
        apply_reset();
        model_en  = 1'b1;
        dly       = 30;
        req_data  = 32'h005C_0000;
        req_valid = 4'b0100;
        wait_starts(2, 200, "t3 start bound");
        req_valid = '0;
        if (start_q.size() >= 2 && done_q.size() >= 1) begin
            check("t3 gap",       32'(start_q[1] - done_q[0]), 32'd5);
            check("t3 byte1",     32'(byte_q[1]),              32'h5C);
            check("t3 ready0",    32'(rdy_q[0]),               32'h4);
            check("t3 ready1",    32'(rdy_q[1]),               32'h4);
        end
        wait_idle(100, "t3 idle bound", fall);

        // Pointer wrap from grant_id=3 with requesters 0 and 2
        apply_reset();
        model_en  = 1'b1;
        dly       = 10;
        req_data  = 32'h0002_0001;
        req_valid = 4'b0101;
        @(negedge clk);
        check("t4 grant_id", 32'(grant_id),  32'd0);
        check("t4 ready",    32'(req_ready), 32'h1);
        check("t4 txin",     32'(uart_txin), 32'h01);
        wait_starts(2, 100, "t4 start bound");
        req_valid = '0;
        check("t4 grant_id2", 32'(grant_id), 32'd2);
        if (byte_q.size() >= 2) check("t4 byte2", 32'(byte_q[1]), 32'h02);
        wait_idle(100, "t4 idle bound", fall);

        // Reset mid-WAIT, then a stray txdone in IDLE
        apply_reset();
        req_data  = 32'h0000_7700;
        req_valid = 4'b0010;
        @(negedge clk);
        check("t5 start", 32'(uart_start), 32'd1);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5 rst busy",     32'(busy),       32'd0);
        check("t5 rst grant_id", 32'(grant_id),   32'd3);
        check("t5 rst start",    32'(uart_start), 32'd0);
        clear_logs();
        done_req = 1'b1;
        repeat (10) @(negedge clk);
        check("t5 stray done seen", 32'(done_q.size()),  32'd1);
        check("t5 no start",        32'(start_q.size()), 32'd0);
        check("t5 stays idle",      32'(busy),           32'd0);

        // Missing txdone: watchdog when built, otherwise indefinite WAIT
        apply_reset();
        req_data  = 32'hEE00_0000;
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6 grant_id", 32'(grant_id),  32'd3);
        check("t6 txin",     32'(uart_txin), 32'hEE);
        req_data  = 32'h0000_0044;
        req_valid = 4'b0001;
        s0 = (start_q.size() > 0) ? start_q[0] : 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 200 && to_q.size() < 1; i++) @(negedge clk);
        check("t6 timeout seen", 32'(to_q.size()), 32'd1);
        if (to_q.size() >= 1) check("t6 timeout cycle", 32'(to_q[0] - s0), 32'd50);
        wait_starts(2, 100, "t6 start bound");
        req_valid = '0;
        if (start_q.size() >= 2) begin
            check("t6 next start", 32'(start_q[1] - s0), 32'd54);
            check("t6 next byte",  32'(byte_q[1]),       32'h44);
        end
`else
        repeat (300) @(negedge clk);
        req_valid = '0;
        check("t6 busy held",  32'(busy),            32'd1);
        check("t6 no timeout", 32'(to_q.size()),     32'd0);
        check("t6 one start",  32'(start_q.size()),  32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
